// File: rtl/dpram_portb_arbiter.sv
// Round-robin arbiter sharing RAM port B between two masters (IDLE -> ACCESS -> ACK).
// Define DPRAM_ARB_FIXED_PRIO_EN to give master 0 fixed priority instead of round robin.
module dpram_portb_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic              m0_grnt,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rd_data,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m1_grnt,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_owner;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_we;
  logic [DATA_W-1:0] r_ram_din;

  logic w_idle_win;
  logic w_ack_go;
  logic w_load;
  logic w_win;

`ifdef DPRAM_ARB_FIXED_PRIO_EN
  assign w_idle_win = ~m0_req;
  // A still-high m0_req after its own ack is a re-request; park in IDLE so m0 wins again.
  assign w_ack_go   = r_owner ? m0_req : (m1_req & ~m0_req);
`else
  logic r_last_owner;
  assign w_idle_win = (m0_req & m1_req) ? ~r_last_owner : m1_req;
  assign w_ack_go   = r_owner ? m0_req : m1_req;
`endif

  assign w_win  = (r_state == S_ACK) ? ~r_owner : w_idle_win;
  assign w_load = ((r_state == S_IDLE) & (m0_req | m1_req)) |
                  ((r_state == S_ACK) & w_ack_go);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b0;
      r_ram_addr <= '0;
      r_ram_we   <= 1'b0;
      r_ram_din  <= '0;
`ifndef DPRAM_ARB_FIXED_PRIO_EN
      r_last_owner <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_ACK: begin
          if (w_load) begin
            r_owner    <= w_win;
            r_ram_addr <= w_win ? m1_addr : m0_addr;
            r_ram_we   <= w_win ? m1_we : m0_we;
            r_ram_din  <= w_win ? m1_wr_data : m0_wr_data;
            r_state    <= S_ACCESS;
          end else begin
            r_ram_we <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_ACCESS: begin
          r_ram_we <= 1'b0;
`ifndef DPRAM_ARB_FIXED_PRIO_EN
          r_last_owner <= r_owner;
`endif
          r_state <= S_ACK;
        end
        default: begin
          r_ram_we <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign ram_addr  = r_ram_addr;
  assign ram_we    = r_ram_we;
  assign ram_din   = r_ram_din;
  assign dbg_state = r_state;

  // Grant/ack decode only registered state; read data is a straight mux of the RAM output.
  assign m0_grnt    = (r_state != S_IDLE) & ~r_owner;
  assign m1_grnt    = (r_state != S_IDLE) & r_owner;
  assign m0_ack     = (r_state == S_ACK) & ~r_owner;
  assign m1_ack     = (r_state == S_ACK) & r_owner;
  assign m0_rd_data = m0_ack ? ram_dout : '0;
  assign m1_rd_data = m1_ack ? ram_dout : '0;

endmodule

// File: doc/dpram_portb_arbiter.md
Name: dpram_portb_arbiter

Overview:
- Two-requester arbiter that shares port B of the 4096x32 dual-port RAM between master 0 (CPU data path) and master 1 (DMA/bus bridge).
- Port A stays dedicated to instruction fetch and is untouched by this block.
- Sequences each access through a small FSM that matches the RAM's one-cycle synchronous read latency.
- Returns the read data or write completion with a one-cycle ack to the owning master.

Parameters:
- ADDR_W, 12, RAM word-address width.
- DATA_W, 32, RAM data width.

Ports:
- clk  in  1  single clock, rising edge; also drives the RAM port-B clock.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  master 0 access request; held until m0_ack.
- m0_we  in  1  master 0 write enable (1=write, 0=read); stable while m0_req=1.
- m0_addr  in  ADDR_W  master 0 word address; stable while m0_req=1.
- m0_wr_data  in  DATA_W  master 0 write data; stable while m0_req=1.
- m0_grnt  out  1  master 0 owns port B (ACCESS or ACK state).
- m0_ack  out  1  one-cycle completion strobe for master 0.
- m0_rd_data  out  DATA_W  read data; valid only while m0_ack=1.
- m1_req, m1_we, m1_addr, m1_wr_data, m1_grnt, m1_ack, m1_rd_data: identical to the m0_* ports, for master 1.
- ram_addr  out  ADDR_W  to RAM addrb.
- ram_we  out  1  to RAM web.
- ram_din  out  DATA_W  to RAM dinb.
- ram_dout  in  DATA_W  from RAM doutb.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, owner=0, last_owner=1, so master 0 wins the first tie.
  - ram_addr=0, ram_we=0, ram_din=0.
  - All grnt and ack outputs are 0; both rd_data outputs are 0.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - If any req=1, arbitrate, register the winner's addr/we/wr_data into ram_addr/ram_we/ram_din, set owner, and go to ACCESS.
  - Otherwise stay in IDLE with ram_we=0.
- Arbitration rule:
  - If only one master requests, it wins.
  - If both request, the master that is not last_owner wins (round robin).
- ACCESS (1 cycle):
  - ram_* outputs are held and the RAM samples them at the closing edge.
  - On exit, ram_we is cleared to 0.
  - Always go to ACK and set last_owner=owner.
- ACK (1 cycle):
  - m{owner}_ack=1.
  - m{owner}_rd_data=ram_dout for reads; for writes ram_dout is passed through unchanged and shall be ignored by the master.
  - Non-owner rd_data=0.
  - The acked master's req is ignored this cycle; the master shall drop it on the next cycle or re-raise it for a new access.
  - If the other master's req=1, re-arbitrate exactly as in IDLE (it wins), load ram_*, and go to ACCESS, so back-to-back transfers are 2 cycles each.
  - Otherwise go to IDLE.
- Timing:
  - Latency from req sampled in IDLE to ack is 2 cycles.
  - Minimum time between acks is 2 cycles when alternating masters, 3 cycles for the same master.
- Outputs:
  - grnt and ack are decoded from registered state/owner; no combinational path from req to grnt or ack.
  - rd_data is a combinational mux of ram_dout.
- Both masters hammering continuously: strict alternation, neither master is starved for more than one access.
- A req that drops before grant is treated as withdrawn; the master shall not do this, and no RAM write occurs for it.
- Reset asserted in ACCESS with ram_we=1: ram_we goes to 0 asynchronously.
  - The RAM write on that edge is not guaranteed.
  - No ack is issued.
- Address/data width: values pass straight through, no arithmetic; ADDR_W and DATA_W must match the RAM instance.

Optional Feature:
- Macro: DPRAM_ARB_FIXED_PRIO_EN.
- Defined: master 0 always wins simultaneous requests and last_owner is unused; master 1 can be starved while m0_req stays high.
- Undefined (default): round-robin as above.

Test Plan:
- Single write then read:
  - m0 write addr=0x010, data=0xDEADBEEF; expect m0_ack 2 cycles after req and ram_we=1 for exactly 1 cycle.
  - m0 read addr=0x010; expect m0_rd_data=0xDEADBEEF while m0_ack=1.
- Simultaneous requests after reset:
  - m0 reads 0x001 and m1 reads 0x002 from the same cycle.
  - Expect m0_ack first, m1_ack 2 cycles later, with correct data for each.
- Continuous contention:
  - Both reqs held high for 8 accesses.
  - Acks alternate m0, m1, m0, …, 2 cycles apart.
  - With DPRAM_ARB_FIXED_PRIO_EN defined, m1_ack never occurs while m0 re-requests.
- Same-master back-to-back:
  - m1 issues 3 writes to 0xFFF, 0x000, 0x7FF with data 1, 2, 3.
  - Acks 3 cycles apart; read back returns 1, 2, 3.
- Async reset mid-access:
  - Assert reset between clock edges during ACCESS of an m0 write.
  - ram_we, grnt, and ack drop immediately.
  - After release, an m1 read of 0x020 completes normally with latency 2.
- Port-A coexistence:
  - The bench drives RAM port A with a write to 0x030 (0x12345678) while the arbiter issues an m0 read of 0x030 on port B in the same cycle.
  - m0_rd_data=0x12345678.
